// File: rtl/mdc_delay_commutator.sv
// Delay-commutator stage of a radix-2 MDC FFT pipeline: pairs x[n] with x[n+DELAY] on one beat.
// Lower pre-delay, 2x2 swap switch and upper post-delay, all advancing only on accepted beats.
module mdc_delay_commutator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DELAY = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  output logic             out_sof,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1
);

  localparam int unsigned CntW   = $clog2(2 * DELAY);
  localparam int unsigned SelBit = $clog2(DELAY);
  localparam int unsigned FillW  = $clog2(DELAY + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(DELAY);

  if ((DELAY == 0) || (DELAY > 256) || ((DELAY & (DELAY - 1)) != 0)) begin : g_bad_delay
    $error("DELAY must be a power of two between 1 and 256");
  end

  logic             adv;
  logic [CntW-1:0]  cnt_q, cnt_d, phase;
  logic             sel;
  logic [FillW-1:0] fill_q, fill_d;
  logic             primed;
  logic             seen_q, seen_d;
  logic [WIDTH-1:0] low_q [DELAY];
  logic [WIDTH-1:0] top_q [DELAY];
  logic [WIDTH-1:0] d1, dtop, s_top, s_bot;

  logic             out_valid_q, out_sof_q;
  logic [WIDTH-1:0] out0_q, out1_q;

  always_comb begin
    adv   = in_valid;
    phase = in_sof ? '0 : cnt_q;
    cnt_d = phase + CntW'(1);
    sel   = phase[SelBit];
    d1    = low_q[DELAY-1];
    dtop  = top_q[DELAY-1];

    s_top = in0;
    s_bot = d1;
    if (sel) begin
      s_top = d1;
      s_bot = in0;
    end

    // A frame start counts as the first beat of a fresh fill.
    fill_d = fill_q;
    if (in_sof) begin
      fill_d = FillW'(1);
    end else if (fill_q != FillFull) begin
      fill_d = fill_q + FillW'(1);
    end

    primed = !in_sof && (fill_q == FillFull);
    // seen marks that the frame's first valid pair has already gone out.
    seen_d = !in_sof && (seen_q || primed);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      fill_q      <= '0;
      seen_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
    end else if (adv) begin
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      seen_q      <= seen_d;
      out_valid_q <= primed;
      out_sof_q   <= primed && !seen_q;
      out0_q      <= dtop;
      out1_q      <= s_bot;
    end else begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end
  end

  // Delay-line contents stay unreset; stale entries are masked by the fill count.
  always_ff @(posedge clock) begin
    if (adv) begin
      low_q[0] <= in1;
      top_q[0] <= s_top;
      for (int i = 1; i < DELAY; i++) begin
        low_q[i] <= low_q[i-1];
        top_q[i] <= top_q[i-1];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out0      = out0_q;
  assign out1      = out1_q;

endmodule

// File: tb/tb_mdc_delay_commutator.sv
// Bench for mdc_delay_commutator: four instances (DELAY 2, 1, 4, 256) share one stimulus stream
// and are checked against literal pair tables and a frame-index reference model.
module tb_mdc_delay_commutator;

  localparam int NDut    = 4;
  localparam int HistLen = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_sof;
  logic [31:0] in0, in1;

  always #5 clock = ~clock;

  logic [NDut-1:0] ov, os;
  logic [15:0]     o0_a, o1_a, o0_b, o1_b, o0_c, o1_c;
  logic [31:0]     o0_w, o1_w;
  logic [31:0]     o0 [NDut];
  logic [31:0]     o1 [NDut];

  mdc_delay_commutator #(.WIDTH(16), .DELAY(2)) u_d2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in0(in0[15:0]), .in1(in1[15:0]),
    .out_valid(ov[0]), .out_sof(os[0]), .out0(o0_a), .out1(o1_a)
  );
  mdc_delay_commutator #(.WIDTH(16), .DELAY(1)) u_d1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in0(in0[15:0]), .in1(in1[15:0]),
    .out_valid(ov[1]), .out_sof(os[1]), .out0(o0_b), .out1(o1_b)
  );
  mdc_delay_commutator #(.WIDTH(16), .DELAY(4)) u_d4 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in0(in0[15:0]), .in1(in1[15:0]),
    .out_valid(ov[2]), .out_sof(os[2]), .out0(o0_c), .out1(o1_c)
  );
  mdc_delay_commutator #(.WIDTH(32), .DELAY(256)) u_d256 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in0(in0), .in1(in1),
    .out_valid(ov[3]), .out_sof(os[3]), .out0(o0_w), .out1(o1_w)
  );

  assign o0[0] = {16'h0, o0_a};
  assign o1[0] = {16'h0, o1_a};
  assign o0[1] = {16'h0, o0_b};
  assign o1[1] = {16'h0, o1_b};
  assign o0[2] = {16'h0, o0_c};
  assign o1[2] = {16'h0, o1_c};
  assign o0[3] = o0_w;
  assign o1[3] = o1_w;

  int checks;
  int errors;

  // Reference model: n counts accepted beats since the last sof/reset; each output pair
  // is chosen directly from the input history by the position of n within its 2*D group.
  int          n_m    [NDut];
  logic [31:0] h0     [NDut][HistLen];
  logic [31:0] h1     [NDut][HistLen];
  logic        exp_v  [NDut];
  logic        exp_s  [NDut];
  logic        exp_sk [NDut];
  logic        exp_dk [NDut];
  logic [31:0] exp_d0 [NDut];
  logic [31:0] exp_d1 [NDut];

  function automatic int dly(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      2:       return 4;
      default: return 256;
    endcase
  endfunction

  function automatic logic [31:0] msk(input int k, input logic [31:0] x);
    return (k == 3) ? x : {16'h0, x[15:0]};
  endfunction

  task automatic model_edge();
    for (int k = 0; k < NDut; k++) begin
      int d;
      int n;
      d = dly(k);
      if (reset) begin
        n_m[k] = 0;
        exp_v[k] = 1'b0; exp_s[k] = 1'b0; exp_sk[k] = 1'b1; exp_dk[k] = 1'b1;
        exp_d0[k] = '0;  exp_d1[k] = '0;
      end else if (in_valid) begin
        if (in_sof) n_m[k] = 0;
        n = n_m[k];
        h0[k][n % HistLen] = msk(k, in0);
        h1[k][n % HistLen] = msk(k, in1);
        exp_v[k]  = (n >= d);
        exp_s[k]  = (n == d);
        exp_sk[k] = 1'b1;
        exp_dk[k] = (n >= d);
        if (n >= d) begin
          if ((n % (2 * d)) >= d) begin
            exp_d0[k] = h0[k][(n - d) % HistLen];
            exp_d1[k] = h0[k][n % HistLen];
          end else begin
            exp_d0[k] = h1[k][(n - 2 * d) % HistLen];
            exp_d1[k] = h1[k][(n - d) % HistLen];
          end
        end
        n_m[k] = n + 1;
      end else begin
        exp_v[k]  = 1'b0;
        exp_sk[k] = 1'b0;
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_sof   = s;
    in0      = a;
    in1      = b;
    @(posedge clock);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, $urandom, $urandom);
    for (int k = 0; k < NDut; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || os[k] !== 1'b0 || o0[k] !== 32'h0 || o1[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset dut%0d got v=%b s=%b %h/%h want 0 0 0/0", k, ov[k], os[k], o0[k], o1[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_d2_pairs();
    int e0 [6] = '{0, 1, 100, 101, 4, 5};
    int e1 [6] = '{2, 3, 102, 103, 6, 7};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, 32'(i), 32'(100 + i));
      checks++;
      if (ov[0] !== (i >= 2)) begin
        errors++;
        $display("FAIL d2_valid beat %0d got %b want %b", i, ov[0], i >= 2);
      end
      if (i >= 2) begin
        checks++;
        if (o0[0] !== 32'(e0[i-2]) || o1[0] !== 32'(e1[i-2])) begin
          errors++;
          $display("FAIL d2_pair beat %0d got %0d/%0d want %0d/%0d", i, o0[0], o1[0],
                   e0[i-2], e1[i-2]);
        end
        checks++;
        if (os[0] !== (i == 2)) begin
          errors++;
          $display("FAIL d2_sof beat %0d got %b want %b", i, os[0], i == 2);
        end
      end
    end
  endtask

  task automatic test_bubbles();
    int e0 [6] = '{0, 1, 100, 101, 4, 5};
    int e1 [6] = '{2, 3, 102, 103, 6, 7};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, 32'(i), 32'(100 + i));
      checks++;
      if (ov[0] !== (i >= 2)) begin
        errors++;
        $display("FAIL bub_valid beat %0d got %b want %b", i, ov[0], i >= 2);
      end
      if (i >= 2) begin
        checks++;
        if (o0[0] !== 32'(e0[i-2]) || o1[0] !== 32'(e1[i-2]) || os[0] !== (i == 2)) begin
          errors++;
          $display("FAIL bub_pair beat %0d got %0d/%0d sof=%b want %0d/%0d sof=%b", i, o0[0],
                   o1[0], os[0], e0[i-2], e1[i-2], i == 2);
        end
      end
      step(1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom);
      checks++;
      if (ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL bub_gap beat %0d out_valid got %b want 0", i, ov[0]);
      end
      if (i >= 2) begin
        checks++;
        if (o0[0] !== 32'(e0[i-2]) || o1[0] !== 32'(e1[i-2])) begin
          errors++;
          $display("FAIL bub_hold beat %0d got %0d/%0d want %0d/%0d", i, o0[0], o1[0],
                   e0[i-2], e1[i-2]);
        end
      end
    end
  endtask

  task automatic test_d1();
    int e0 [4] = '{0, 10, 2, 12};
    int e1 [4] = '{1, 11, 3, 13};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i == 0, 32'(i), 32'(10 + i));
      checks++;
      if (ov[1] !== (i >= 1)) begin
        errors++;
        $display("FAIL d1_valid beat %0d got %b want %b", i, ov[1], i >= 1);
      end
      if (i >= 1) begin
        checks++;
        if (o0[1] !== 32'(e0[i-1]) || o1[1] !== 32'(e1[i-1]) || os[1] !== (i == 1)) begin
          errors++;
          $display("FAIL d1_pair beat %0d got %0d/%0d sof=%b want %0d/%0d sof=%b", i, o0[1],
                   o1[1], os[1], e0[i-1], e1[i-1], i == 1);
        end
      end
    end
  endtask

  task automatic test_resof();
    logic [31:0] x0 [14];
    for (int i = 0; i < 14; i++) x0[i] = {16'h0, 16'($urandom)};
    for (int i = 0; i < 14; i++) begin
      step(1'b1, (i == 0) || (i == 5), x0[i], $urandom);
      if (i == 4) begin
        checks++;
        if (ov[2] !== 1'b1 || os[2] !== 1'b1 || o0[2] !== x0[0] || o1[2] !== x0[4]) begin
          errors++;
          $display("FAIL resof_first got v=%b s=%b %h/%h want 1 1 %h/%h", ov[2], os[2], o0[2],
                   o1[2], x0[0], x0[4]);
        end
      end
      if (i >= 5 && i <= 8) begin
        checks++;
        if (ov[2] !== 1'b0) begin
          errors++;
          $display("FAIL resof_gap beat %0d out_valid got %b want 0", i, ov[2]);
        end
      end
      if (i == 9 || i == 10) begin
        checks++;
        if (ov[2] !== 1'b1 || os[2] !== (i == 9) || o0[2] !== x0[i-4] || o1[2] !== x0[i]) begin
          errors++;
          $display("FAIL resof_new beat %0d got v=%b s=%b %h/%h want 1 %b %h/%h", i, ov[2],
                   os[2], o0[2], o1[2], i == 9, x0[i-4], x0[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, $urandom, $urandom);
    reset = 1'b1;
    step(1'b1, 1'b0, $urandom, $urandom);
    reset = 1'b0;
    for (int k = 0; k < NDut; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || os[k] !== 1'b0 || o0[k] !== 32'h0 || o1[k] !== 32'h0) begin
        errors++;
        $display("FAIL midreset dut%0d got v=%b s=%b %h/%h want 0 0 0/0", k, ov[k], os[k],
                 o0[k], o1[k]);
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, i == 0, $urandom, $urandom);
      for (int k = 0; k < NDut; k++) begin
        checks++;
        if (ov[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL rerun dut%0d beat %0d out_valid got %b want %b", k, i, ov[k], exp_v[k]);
        end
        if (exp_sk[k]) begin
          checks++;
          if (os[k] !== exp_s[k]) begin
            errors++;
            $display("FAIL rerun dut%0d beat %0d out_sof got %b want %b", k, i, os[k], exp_s[k]);
          end
        end
        if (exp_dk[k]) begin
          checks++;
          if (o0[k] !== exp_d0[k] || o1[k] !== exp_d1[k]) begin
            errors++;
            $display("FAIL rerun dut%0d beat %0d got %h/%h want %h/%h", k, i, o0[k], o1[k],
                     exp_d0[k], exp_d1[k]);
          end
        end
      end
    end
  endtask

  task automatic test_long();
    for (int i = 0; i < 2048; i++) begin
      step(1'b1, i == 0, $urandom, $urandom);
      checks++;
      if (ov[3] !== exp_v[3] || os[3] !== exp_s[3]) begin
        errors++;
        $display("FAIL long beat %0d got v=%b s=%b want v=%b s=%b", i, ov[3], os[3], exp_v[3],
                 exp_s[3]);
      end
      if (exp_dk[3]) begin
        checks++;
        if (o0[3] !== exp_d0[3] || o1[3] !== exp_d1[3]) begin
          errors++;
          $display("FAIL long beat %0d got %h/%h want %h/%h", i, o0[3], o1[3], exp_d0[3],
                   exp_d1[3]);
        end
      end
    end
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom, $urandom);
      for (int k = 0; k < NDut; k++) begin
        checks++;
        if (ov[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL stall dut%0d cyc %0d out_valid got %b want %b", k, i, ov[k], exp_v[k]);
        end
        if (exp_sk[k]) begin
          checks++;
          if (os[k] !== exp_s[k]) begin
            errors++;
            $display("FAIL stall dut%0d cyc %0d out_sof got %b want %b", k, i, os[k], exp_s[k]);
          end
        end
        if (exp_dk[k]) begin
          checks++;
          if (o0[k] !== exp_d0[k] || o1[k] !== exp_d1[k]) begin
            errors++;
            $display("FAIL stall dut%0d cyc %0d got %h/%h want %h/%h", k, i, o0[k], o1[k],
                     exp_d0[k], exp_d1[k]);
          end
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in0      = '0;
    in1      = '0;
    test_reset();
    test_d2_pairs();
    test_bubbles();
    test_d1();
    test_resof();
    test_reset_mid();
    test_long();
    test_random_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
